fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC core. Holds the program counter, drives the combinational instruction ROM address, registers the returned instruction word with its PC, and hands it to the decode stage over a valid/ready handshake. Supports downstream back-pressure, jump redirection with flush, and an optional halt state.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset; width `A_BITS`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  `A_BITS`  address to ROM; always equals the internal PC.
- `rom_data`  in  `D_BITS`  ROM word for `rom_addr`; valid in the same cycle.
- `instr`  out  `D_BITS`  registered instruction to decode.
- `instr_pc`  out  `A_BITS`  address `instr` was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a live instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `jump`  in  1  redirect request, single-cycle pulse.
- `jump_addr`  in  `A_BITS`  redirect target, sampled when `jump`=1.
- `halt`  in  1  stop fetching (only with `FETCH_HALT_EN`).
- `halted`  out  1  fetch unit is in HALTED.

## Operation
- States: FETCH, HALTED. Reset: state=FETCH, PC=`RESET_PC`, `instr`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0.
- Output slot is "free" when `instr_valid`=0 or `instr_ready`=1.
- FETCH, no jump, slot free: `instr`<=`rom_data`, `instr_pc`<=PC, `instr_valid`<=1, PC<=PC+1.
- FETCH, slot not free: PC, `instr`, `instr_pc`, `instr_valid` hold.
- PC increment is modulo 2^`A_BITS`: PC = 2^`A_BITS`-1 wraps to 0; no flag.
- `jump`=1 (any state, any handshake condition): PC<=`jump_addr`, `instr_valid`<=0 (flush, even if unconsumed), state<=FETCH. Highest priority below reset.
- `halt`=1 in FETCH, no jump: state<=HALTED; no fetch that cycle; PC holds. A held valid instruction is kept until accepted, then `instr_valid`<=0.
- HALTED: no fetches, PC frozen, `halted`=1. Exit only via `jump` or reset; `halt` deassertion alone does not resume.
- `halt` and `jump` same cycle: jump wins, state FETCH.
- Reset asserted mid-operation: all outputs take reset values immediately, independent of `clk`.

## Timing
- ROM is combinational: PC to `rom_data` within the cycle; no wait states.
- Reset-release to first `instr_valid`=1: one rising edge.
- Steady state with `instr_ready`=1: one instruction per cycle, `instr_pc` incrementing by 1.
- Jump penalty: one bubble; target instruction valid on the second edge after `jump` sampled.
- `instr_ready` affects only the next edge; outputs never change combinationally from inputs except via `rst`.

## Configuration
- `FETCH_HALT_EN` defined: `halt` and the HALTED state behave as above.
- Not defined: `halt` ignored, HALTED unreachable, `halted` tied 0; ports remain present.

## Test plan
- ROM[0..2]={`ADD`,`R0`,`R1`,`R2`}, 5, 7; `RESET_PC`=0, `instr_ready`=1, release `rst` -> after 1st edge `instr`=ROM[0], `instr_pc`=0; then ROM[1]/1, ROM[2]/2 on consecutive edges.
- `instr_ready`=0 for 3 cycles while `instr_pc`=1 -> `instr`, `instr_pc`=1, `rom_addr`=2 stable; on `instr_ready`=1, next edge `instr_pc`=2.
- ROM[13]=131313; `jump`=1, `jump_addr`=13 while `instr_valid`=1, `instr_ready`=0 -> next edge `instr_valid`=0; following edge `instr`=131313, `instr_pc`=13.
- `jump_addr`=2^`A_BITS`-1 -> that word then `instr_pc`=0 next; no stall at wrap.
- With `FETCH_HALT_EN`: `halt`=1 at `instr_pc`=4 -> `halted`=1, `rom_addr` frozen at 5, `instr_valid` drops after accept; `halt`=0 keeps halted; `jump` to 10 resumes at `instr_pc`=10. Without macro: `halt` has no effect.
- `rst` low between edges mid-stream -> `instr_valid`=0, `rom_addr`=`RESET_PC` immediately; fetch restarts at `RESET_PC` after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, combinational ROM address, registered instruction
// slot with valid/ready handshake, jump redirect/flush. Optional halt: FETCH_HALT_EN.
module fetch_unit #(
  parameter int               A_BITS   = 8,
  parameter int               D_BITS   = 32,
  parameter logic [A_BITS-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [A_BITS-1:0] rom_addr,
  input  logic [D_BITS-1:0] rom_data,
  output logic [D_BITS-1:0] instr,
  output logic [A_BITS-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [A_BITS-1:0] jump_addr,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic {ST_FETCH, ST_HALTED} state_t;

  state_t              state_reg, state_next;
  logic [A_BITS-1:0]   pc_reg, pc_next;
  logic [D_BITS-1:0]   instr_reg, instr_next;
  logic [A_BITS-1:0]   instr_pc_reg, instr_pc_next;
  logic                valid_reg, valid_next;
  logic                slot_free;
  logic                halt_req;

`ifdef FETCH_HALT_EN
  assign halt_req = halt;
`else
  // Halt is ignored in this build; the port stays for interface compatibility.
  assign halt_req = 1'b0 & halt;
`endif

  assign slot_free = !valid_reg || instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    if (jump) begin
      // Redirect flushes the slot even if decode never took it.
      state_next = ST_FETCH;
      pc_next    = jump_addr;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (halt_req) begin
            state_next = ST_HALTED;
            if (slot_free) valid_next = 1'b0;
          end else if (slot_free) begin
            instr_next    = rom_data;
            instr_pc_next = pc_reg;
            valid_next    = 1'b1;
            pc_next       = pc_reg + A_BITS'(1);
          end
        end
        ST_HALTED: begin
          // Drain the pending instruction, never refill.
          if (slot_free) valid_next = 1'b0;
        end
        default: state_next = ST_FETCH;
      endcase
    end
  end

  assign rom_addr    = pc_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
  assign halted      = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, halt/reset sequences and
// randomized traffic against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int AB    = 5;
  localparam int DB    = 32;
  localparam int DEPTH = 1 << AB;
`ifdef FETCH_HALT_EN
  localparam bit HALT_M = 1'b1;
`else
  localparam bit HALT_M = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AB-1:0] rom_addr;
  logic [DB-1:0] rom_data;
  logic [DB-1:0] instr;
  logic [AB-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          jump = 1'b0;
  logic [AB-1:0] jump_addr = '0;
  logic          halt = 1'b0;
  logic          halted;

  logic [DB-1:0] rom [DEPTH];
  assign rom_data = rom[rom_addr];

  fetch_unit #(.A_BITS(AB), .D_BITS(DB), .RESET_PC(5'd0)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump(jump), .jump_addr(jump_addr),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // model state
  int m_pc, m_ipc, m_valid, m_halted;
  logic [DB-1:0] m_instr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_valid = 0; m_halted = 0; m_instr = '0;
  endtask

  // Advance one clock; model applies the fetch rules to the inputs seen at the edge.
  task automatic tick();
    int n_pc, n_ipc, n_valid, n_halted;
    logic [DB-1:0] n_instr;
    bit free;
    free = (m_valid == 0) || instr_ready;
    n_pc = m_pc; n_ipc = m_ipc; n_valid = m_valid; n_halted = m_halted; n_instr = m_instr;
    if (jump) begin
      n_pc = int'(jump_addr); n_valid = 0; n_halted = 0;
    end else if (m_halted != 0 || (HALT_M && halt)) begin
      n_halted = 1;
      if (free) n_valid = 0;
    end else if (free) begin
      n_instr = rom[m_pc]; n_ipc = m_pc; n_valid = 1; n_pc = (m_pc + 1) % DEPTH;
    end
    @(posedge clk); #1;
    m_pc = n_pc; m_ipc = n_ipc; m_valid = n_valid; m_halted = n_halted; m_instr = n_instr;
  endtask

  task automatic drive(input logic r, input logic j, input logic [AB-1:0] ja, input logic h);
    instr_ready = r; jump = j; jump_addr = ja; halt = h;
  endtask

  typedef struct {
    logic          rdy;
    logic          jmp;
    logic [AB-1:0] jaddr;
    logic          hlt;
    logic          ev;
    logic [AB-1:0] eipc;
    logic [DB-1:0] einstr;
    logic [AB-1:0] eaddr;
  } vec_t;

  localparam logic [DB-1:0] W_ADD = 32'h0010_0102;  // ADD R0,R1,R2
  localparam logic [DB-1:0] W_TOP = 32'hFFFF_0031;

  vec_t vecs[11];

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0] = W_ADD; rom[1] = 32'd5; rom[2] = 32'd7; rom[13] = 32'd131313; rom[31] = W_TOP;

    vecs[0]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  W_ADD,      5'd1};
    vecs[1]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  32'd5,      5'd2};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  32'd5,      5'd2};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  32'd5,      5'd2};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  32'd5,      5'd2};
    vecs[5]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd2,  32'd7,      5'd3};
    vecs[6]  = '{1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 5'd0,  32'd0,      5'd13};
    vecs[7]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd13, 32'd131313, 5'd14};
    vecs[8]  = '{1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 5'd0,  32'd0,      5'd31};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd31, W_TOP,      5'd0};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  W_ADD,      5'd1};

    // reset state
    model_reset();
    #12;
    chk("reset_valid", 64'(instr_valid), 64'd0);
    chk("reset_addr",  64'(rom_addr),    64'd0);
    chk("reset_instr", 64'(instr),       64'd0);
    chk("reset_ipc",   64'(instr_pc),    64'd0);
    chk("reset_halted", 64'(halted),     64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rdy, vecs[i].jmp, vecs[i].jaddr, vecs[i].hlt);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(instr_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_addr", i),  64'(rom_addr),    64'(vecs[i].eaddr));
      chk($sformatf("vec%0d_halted", i), 64'(halted),     64'd0);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_ipc", i),   64'(instr_pc), 64'(vecs[i].eipc));
        chk($sformatf("vec%0d_instr", i), 64'(instr),    64'(vecs[i].einstr));
      end
      $display("vec %0d: valid=%0d pc=%0d instr=%0h addr=%0d", i, instr_valid, instr_pc, instr, rom_addr);
    end

    // advance to instr_pc=4
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_halt_ipc", 64'(instr_pc), 64'd4);
`ifdef FETCH_HALT_EN
    drive(1'b0, 1'b0, 5'd0, 1'b1); tick();
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_keep_valid", 64'(instr_valid), 64'd1);
    chk("halt_addr", 64'(rom_addr), 64'd5);
    drive(1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("halt_sticky", 64'(halted), 64'd1);
    chk("halt_ipc_hold", 64'(instr_pc), 64'd4);
    drive(1'b1, 1'b0, 5'd0, 1'b0); tick();
    chk("halt_drain_valid", 64'(instr_valid), 64'd0);
    tick(); tick();
    chk("halt_frozen_addr", 64'(rom_addr), 64'd5);
    chk("halt_still", 64'(halted), 64'd1);
    chk("halt_no_fetch", 64'(instr_valid), 64'd0);
    drive(1'b1, 1'b1, 5'd10, 1'b0); tick();
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_addr", 64'(rom_addr), 64'd10);
    drive(1'b1, 1'b0, 5'd0, 1'b0); tick();
    chk("resume_valid", 64'(instr_valid), 64'd1);
    chk("resume_ipc", 64'(instr_pc), 64'd10);
    chk("resume_instr", 64'(instr), 64'(rom[10]));
`else
    drive(1'b1, 1'b0, 5'd0, 1'b1); tick();
    chk("nohalt_halted", 64'(halted), 64'd0);
    chk("nohalt_ipc", 64'(instr_pc), 64'd5);
    chk("nohalt_addr", 64'(rom_addr), 64'd6);
    drive(1'b1, 1'b0, 5'd0, 1'b0);
`endif
    $display("halt seq: halted=%0d valid=%0d pc=%0d addr=%0d", halted, instr_valid, instr_pc, rom_addr);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
            AB'($urandom), 1'($urandom_range(0, 9) == 0));
      tick();
      chk("rnd_valid",  64'(instr_valid), 64'(m_valid));
      chk("rnd_addr",   64'(rom_addr),    64'(m_pc));
      chk("rnd_halted", 64'(halted),      64'(m_halted));
      if (m_valid != 0) begin
        chk("rnd_ipc",   64'(instr_pc), 64'(m_ipc));
        chk("rnd_instr", 64'(instr),    64'(m_instr));
      end
      $display("rnd %0d: rdy=%0d jmp=%0d halt=%0d valid=%0d pc=%0d addr=%0d", c, instr_ready, jump, halt, instr_valid, instr_pc, rom_addr);
    end

    // asynchronous reset between edges mid-stream
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid",  64'(instr_valid), 64'd0);
    chk("arst_addr",   64'(rom_addr),    64'd0);
    chk("arst_halted", 64'(halted),      64'd0);
    chk("arst_ipc",    64'(instr_pc),    64'd0);
    @(posedge clk); #1;
    chk("arst_hold_valid", 64'(instr_valid), 64'd0);
    rst = 1'b1;
    model_reset();
    tick();
    chk("arst_restart_valid", 64'(instr_valid), 64'd1);
    chk("arst_restart_ipc",   64'(instr_pc),    64'd0);
    chk("arst_restart_instr", 64'(instr),       64'(W_ADD));
    $display("reset seq: valid=%0d pc=%0d addr=%0d", instr_valid, instr_pc, rom_addr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
